// File: rtl/des_key_schedule.sv
// DES subkey generator: PC-1 load, per-round C/D rotation, PC-2 selection.
// Emits K1..K16 (or K16..K1 for decryption) over a valid/ready handshake.
`timescale 1ns/1ps
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_idx,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        sched_done
);
    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic        key_ready_q, key_ready_d;
    logic        done_q, done_d;
    logic [55:0] pc1_key;
    logic [3:0]  nxt;
    logic        one_step;

    // FIPS bit 1 is the MSB of every vector.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1[j]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
        return r;
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] x,
                                        input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] x,
                                        input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    always_comb begin
        pc1_key  = pc1(key_in);
        nxt      = idx_q + 4'd1;
        one_step = (nxt == 4'd1) || (nxt == 4'd8) || (nxt == 4'd15);

        state_d     = state_q;
        c_d         = c_q;
        d_d         = d_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        key_ready_d = key_ready_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                key_ready_d = 1'b1;
                if (key_valid && key_ready_q) begin
                    mode_d      = decrypt;
                    idx_d       = 4'd0;
                    state_d     = EMIT;
                    key_ready_d = 1'b0;
                    // Decryption starts from C16/D16, which equals C0/D0.
                    if (decrypt) begin
                        c_d = pc1_key[55:28];
                        d_d = pc1_key[27:0];
                    end else begin
                        c_d = rol(pc1_key[55:28], 1'b1);
                        d_d = rol(pc1_key[27:0], 1'b1);
                    end
                end
            end
            EMIT: begin
                key_ready_d = 1'b0;
                if (subkey_ready) begin
                    if (idx_q == LAST) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        key_ready_d = 1'b1;
                    end else begin
                        idx_d = nxt;
                        c_d   = mode_q ? ror(c_q, one_step) : rol(c_q, one_step);
                        d_d   = mode_q ? ror(d_q, one_step) : rol(d_q, one_step);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= 28'd0;
            d_q         <= 28'd0;
            idx_q       <= 4'd0;
            mode_q      <= 1'b0;
            key_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            d_q         <= d_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            key_ready_q <= key_ready_d;
            done_q      <= done_d;
        end
    end

    assign key_ready    = key_ready_q;
    assign subkey_valid = (state_q == EMIT);
    assign subkey_idx   = idx_q;
    assign sched_done   = done_q;
    assign subkey       = pc2({c_q, d_q});

endmodule
